// File: rtl/reservation_station_pkg.sv
// Shared sizing constants for the reservation station slice.
package reservation_station_pkg;
  localparam int RS_SIZE_DEF = 16;
  localparam int ROB_W_DEF   = 5;
  // ROB tag value meaning "operand value already present"
  localparam int NO_DEP      = 0;
endpackage

// File: rtl/reservation_station_prio_enc.sv
// Lowest-set-bit priority encoder; purely combinational, found_o=0 when req_i is empty.
module rs_prio_enc #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IDX_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Buffers dispatched ops until both operands arrive (CDB snoop), issues one ready entry per cycle.
// Dispatch-to-issue latency 2 cycles; rs_full asserts with one free slot left for the in-flight op.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int RS_SIZE = RS_SIZE_DEF,
  parameter int ROB_W   = ROB_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             wrong_commit,
  input  logic             in_valid,
  input  logic [6:0]       in_op,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_pc,
  input  logic [ROB_W-1:0] in_Qi,
  input  logic [ROB_W-1:0] in_Qj,
  input  logic [31:0]      in_Vi,
  input  logic [31:0]      in_Vj,
  input  logic [ROB_W-1:0] in_rob_id,
  output logic             rs_full,
  input  logic             alu_valid,
  input  logic [31:0]      alu_res,
  input  logic [ROB_W-1:0] alu_rob_id,
  input  logic             lsb_valid,
  input  logic [31:0]      lsb_res,
  input  logic [ROB_W-1:0] lsb_rob_id,
  output logic             iss_valid,
  output logic [6:0]       iss_op,
  output logic [31:0]      iss_imm,
  output logic [31:0]      iss_pc,
  output logic [31:0]      iss_Vi,
  output logic [31:0]      iss_Vj,
  output logic [ROB_W-1:0] iss_rob_id
);

  localparam int IDX_W = $clog2(RS_SIZE);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_SIZE-1:0] busy_q, busy_d;
  logic [6:0]         op_q  [RS_SIZE];
  logic [6:0]         op_d  [RS_SIZE];
  logic [31:0]        imm_q [RS_SIZE];
  logic [31:0]        imm_d [RS_SIZE];
  logic [31:0]        pc_q  [RS_SIZE];
  logic [31:0]        pc_d  [RS_SIZE];
  logic [ROB_W-1:0]   qi_q  [RS_SIZE];
  logic [ROB_W-1:0]   qi_d  [RS_SIZE];
  logic [ROB_W-1:0]   qj_q  [RS_SIZE];
  logic [ROB_W-1:0]   qj_d  [RS_SIZE];
  logic [31:0]        vi_q  [RS_SIZE];
  logic [31:0]        vi_d  [RS_SIZE];
  logic [31:0]        vj_q  [RS_SIZE];
  logic [31:0]        vj_d  [RS_SIZE];
  logic [ROB_W-1:0]   rob_q [RS_SIZE];
  logic [ROB_W-1:0]   rob_d [RS_SIZE];
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               iss_valid_q, iss_valid_d;
  logic [6:0]         iss_op_q, iss_op_d;
  logic [31:0]        iss_imm_q, iss_imm_d;
  logic [31:0]        iss_pc_q, iss_pc_d;
  logic [31:0]        iss_vi_q, iss_vi_d;
  logic [31:0]        iss_vj_q, iss_vj_d;
  logic [ROB_W-1:0]   iss_rob_q, iss_rob_d;

  logic [RS_SIZE-1:0] ready;
  logic [IDX_W-1:0]   free_idx, iss_idx;
  logic               free_found, iss_found, disp_acc;

  function automatic logic tag_hit(input logic [ROB_W-1:0] q, input logic vld,
                                   input logic [ROB_W-1:0] tag);
    return vld && (q != ROB_W'(NO_DEP)) && (q == tag);
  endfunction

  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ready[i] = busy_q[i] && (qi_q[i] == ROB_W'(NO_DEP)) && (qj_q[i] == ROB_W'(NO_DEP));
    end
  end

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_free_enc (
    .req_i   (~busy_q),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  rs_prio_enc #(.N(RS_SIZE), .IDX_W(IDX_W)) u_iss_enc (
    .req_i   (ready),
    .idx_o   (iss_idx),
    .found_o (iss_found)
  );

  assign disp_acc = in_valid && free_found;

  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    imm_d  = imm_q;
    pc_d   = pc_q;
    qi_d   = qi_q;
    qj_d   = qj_q;
    vi_d   = vi_q;
    vj_d   = vj_q;
    rob_d  = rob_q;

    // CDB wakeup; ALU checked first so it wins on equal tags
    for (int i = 0; i < RS_SIZE; i++) begin
      if (busy_q[i]) begin
        if (tag_hit(qi_q[i], alu_valid, alu_rob_id)) begin
          qi_d[i] = '0;
          vi_d[i] = alu_res;
        end else if (tag_hit(qi_q[i], lsb_valid, lsb_rob_id)) begin
          qi_d[i] = '0;
          vi_d[i] = lsb_res;
        end
        if (tag_hit(qj_q[i], alu_valid, alu_rob_id)) begin
          qj_d[i] = '0;
          vj_d[i] = alu_res;
        end else if (tag_hit(qj_q[i], lsb_valid, lsb_rob_id)) begin
          qj_d[i] = '0;
          vj_d[i] = lsb_res;
        end
      end
    end

    if (iss_found) begin
      busy_d[iss_idx] = 1'b0;
    end

    if (disp_acc) begin
      busy_d[free_idx] = 1'b1;
      op_d[free_idx]   = in_op;
      imm_d[free_idx]  = in_imm;
      pc_d[free_idx]   = in_pc;
      rob_d[free_idx]  = in_rob_id;
      qi_d[free_idx]   = in_Qi;
      vi_d[free_idx]   = in_Vi;
      qj_d[free_idx]   = in_Qj;
      vj_d[free_idx]   = in_Vj;
      if (tag_hit(in_Qi, alu_valid, alu_rob_id)) begin
        qi_d[free_idx] = '0;
        vi_d[free_idx] = alu_res;
      end else if (tag_hit(in_Qi, lsb_valid, lsb_rob_id)) begin
        qi_d[free_idx] = '0;
        vi_d[free_idx] = lsb_res;
      end
      if (tag_hit(in_Qj, alu_valid, alu_rob_id)) begin
        qj_d[free_idx] = '0;
        vj_d[free_idx] = alu_res;
      end else if (tag_hit(in_Qj, lsb_valid, lsb_rob_id)) begin
        qj_d[free_idx] = '0;
        vj_d[free_idx] = lsb_res;
      end
    end

    cnt_d = cnt_q + CNT_W'(disp_acc) - CNT_W'(iss_found);

    iss_valid_d = iss_found;
    iss_op_d    = iss_op_q;
    iss_imm_d   = iss_imm_q;
    iss_pc_d    = iss_pc_q;
    iss_vi_d    = iss_vi_q;
    iss_vj_d    = iss_vj_q;
    iss_rob_d   = iss_rob_q;
    if (iss_found) begin
      iss_op_d  = op_q[iss_idx];
      iss_imm_d = imm_q[iss_idx];
      iss_pc_d  = pc_q[iss_idx];
      iss_vi_d  = vi_q[iss_idx];
      iss_vj_d  = vj_q[iss_idx];
      iss_rob_d = rob_q[iss_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || wrong_commit) begin
      busy_q      <= '0;
      cnt_q       <= '0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_imm_q   <= '0;
      iss_pc_q    <= '0;
      iss_vi_q    <= '0;
      iss_vj_q    <= '0;
      iss_rob_q   <= '0;
    end else if (rdy) begin
      busy_q      <= busy_d;
      op_q        <= op_d;
      imm_q       <= imm_d;
      pc_q        <= pc_d;
      qi_q        <= qi_d;
      qj_q        <= qj_d;
      vi_q        <= vi_d;
      vj_q        <= vj_d;
      rob_q       <= rob_d;
      cnt_q       <= cnt_d;
      iss_valid_q <= iss_valid_d;
      iss_op_q    <= iss_op_d;
      iss_imm_q   <= iss_imm_d;
      iss_pc_q    <= iss_pc_d;
      iss_vi_q    <= iss_vi_d;
      iss_vj_q    <= iss_vj_d;
      iss_rob_q   <= iss_rob_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !wrong_commit && rdy && in_valid) begin
      assert (free_found) else $error("reservation_station: dispatch with no free slot");
    end
  end

  assign rs_full    = (cnt_q >= CNT_W'(RS_SIZE - 1));
  assign iss_valid  = iss_valid_q;
  assign iss_op     = iss_op_q;
  assign iss_imm    = iss_imm_q;
  assign iss_pc     = iss_pc_q;
  assign iss_Vi     = iss_vi_q;
  assign iss_Vj     = iss_vj_q;
  assign iss_rob_id = iss_rob_q;

endmodule
